// File: rtl/led_pattern_seq_pkg.sv
// Shared constants and types for the LED pattern sequencer.
// Imported by the top, the colour FSM and the bench.
package led_pattern_seq_pkg;

  localparam logic [1:0] MODE_ROT_L    = 2'b00;
  localparam logic [1:0] MODE_ROT_R    = 2'b01;
  localparam logic [1:0] MODE_PINGPONG = 2'b10;
  localparam logic [1:0] MODE_BLINK    = 2'b11;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    C_RED   = 2'd0,
    C_GREEN = 2'd1,
    C_BOTH  = 2'd2
  } colour_t;

endpackage

// File: rtl/led_pattern_seq_if.sv
// Tick/mode inputs and LED bank outputs of the sequencer.
// master drives ticks and mode, slave drives the LEDs.
interface led_pattern_seq_if #(
  parameter int NB_LED = 4
);

  logic              i_valid;
  logic              i_enable;
  logic [1:0]        i_mode;
  logic [NB_LED-1:0] o_led;
  logic [NB_LED-1:0] o_ledR;
  logic [NB_LED-1:0] o_ledG;
  logic              o_dir;
  logic              o_wrap;

  modport master (
    output i_valid,
    output i_enable,
    output i_mode,
    input  o_led,
    input  o_ledR,
    input  o_ledG,
    input  o_dir,
    input  o_wrap
  );

  modport slave (
    input  i_valid,
    input  i_enable,
    input  i_mode,
    output o_led,
    output o_ledR,
    output o_ledG,
    output o_dir,
    output o_wrap
  );

endinterface

// File: rtl/led_pattern_seq_colour_fsm.sv
// Colour state machine: red -> green -> both, one hop per
// completed animation cycle; gates the pattern onto R/G banks.
module led_colour_fsm
  import led_pattern_seq_pkg::*;
#(
  parameter int NB_LED = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wrap_i,
  input  logic [NB_LED-1:0] pat_i,
  output logic [NB_LED-1:0] led_r_o,
  output logic [NB_LED-1:0] led_g_o
);

  colour_t colour_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      colour_q <= C_RED;
    end else if (wrap_i) begin
      unique case (colour_q)
        C_RED:   colour_q <= C_GREEN;
        C_GREEN: colour_q <= C_BOTH;
        C_BOTH:  colour_q <= C_RED;
        default: colour_q <= C_RED;
      endcase
    end
  end

  logic red_en;
  logic grn_en;

  assign red_en = (colour_q == C_RED) || (colour_q == C_BOTH);
  assign grn_en = (colour_q == C_GREEN) || (colour_q == C_BOTH);

  assign led_r_o = red_en ? pat_i : '0;
  assign led_g_o = grn_en ? pat_i : '0;

endmodule

// File: rtl/led_pattern_seq.sv
// LED animation sequencer: advances a selectable pattern
// on each enabled tick and drives main/red/green banks.
module led_pattern_seq
  import led_pattern_seq_pkg::*;
#(
  parameter int              NB_LED   = 4,
  parameter logic [NB_LED-1:0] INIT_PAT =
    {{(NB_LED-1){1'b0}}, 1'b1}
) (
  input  logic              clk,
  input  logic              i_rst,
  led_pattern_seq_if.slave  bus
);

  localparam logic [NB_LED-1:0] MSB_PAT =
    {1'b1, {(NB_LED-1){1'b0}}};

  logic [NB_LED-1:0] pat_q, pat_d;
  logic [1:0]        mode_q, mode_d;
  logic              dir_q, dir_d;
  logic              wrap_q, wrap_d;
  logic              step;
  logic              reload;

  assign step   = bus.i_valid & bus.i_enable;
  assign reload = (bus.i_mode != mode_q);

  always_comb begin
    pat_d  = pat_q;
    mode_d = mode_q;
    dir_d  = dir_q;
    wrap_d = 1'b0;
    if (step && reload) begin
      mode_d = bus.i_mode;
      unique case (bus.i_mode)
        MODE_ROT_L: begin
          pat_d = INIT_PAT;
          dir_d = DIR_LEFT;
        end
        MODE_ROT_R: begin
          pat_d = MSB_PAT;
          dir_d = DIR_RIGHT;
        end
        MODE_PINGPONG: begin
          pat_d = INIT_PAT;
          dir_d = DIR_LEFT;
        end
        MODE_BLINK: begin
          pat_d = '0;
          dir_d = DIR_LEFT;
        end
        default: ;
      endcase
    end else if (step) begin
      unique case (mode_q)
        MODE_ROT_L: begin
          pat_d  = {pat_q[NB_LED-2:0], pat_q[NB_LED-1]};
          wrap_d = pat_q[NB_LED-1];
        end
        MODE_ROT_R: begin
          pat_d  = {pat_q[0], pat_q[NB_LED-1:1]};
          wrap_d = pat_q[0];
        end
        MODE_PINGPONG: begin
          // Bounce off an end bit within the same step.
          if (dir_q == DIR_LEFT) begin
            if (pat_q[NB_LED-1]) begin
              pat_d = pat_q >> 1;
              dir_d = DIR_RIGHT;
            end else begin
              pat_d = pat_q << 1;
            end
          end else begin
            if (pat_q[0]) begin
              pat_d = pat_q << 1;
              dir_d = DIR_LEFT;
            end else begin
              pat_d = pat_q >> 1;
            end
          end
          // Arriving home ends the cycle and faces outwards again.
          if (pat_d == INIT_PAT) begin
            wrap_d = 1'b1;
            dir_d  = DIR_LEFT;
          end
        end
        MODE_BLINK: begin
          pat_d  = (pat_q == '0) ? '1 : '0;
          wrap_d = (pat_q != '0);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      pat_q  <= INIT_PAT;
      mode_q <= MODE_ROT_L;
      dir_q  <= DIR_LEFT;
      wrap_q <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      mode_q <= mode_d;
      dir_q  <= dir_d;
      wrap_q <= wrap_d;
    end
  end

  led_colour_fsm #(
    .NB_LED (NB_LED)
  ) u_colour (
    .clk     (clk),
    .rst_n   (i_rst),
    .wrap_i  (wrap_d),
    .pat_i   (pat_q),
    .led_r_o (bus.o_ledR),
    .led_g_o (bus.o_ledG)
  );

  assign bus.o_led  = pat_q;
  assign bus.o_dir  = dir_q;
  assign bus.o_wrap = wrap_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Directed bench for led_pattern_seq: mode walks, reloads,
// enable gating, colour sequence and async reset.
module tb_led_pattern_seq;
  import led_pattern_seq_pkg::*;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  led_pattern_seq_if #(.NB_LED(4)) bus ();

  led_pattern_seq #(
    .NB_LED   (4),
    .INIT_PAT (4'b0001)
  ) dut (
    .clk   (clk),
    .i_rst (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    bus.i_valid = 1'b1;
    @(negedge clk);
    bus.i_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [3:0] rl_led [5] = '{4'h2, 4'h4, 4'h8, 4'h1, 4'h2};
  logic       rl_wr  [5] = '{0, 0, 0, 1, 0};
  logic [3:0] pp_led [7] = '{4'h2, 4'h4, 4'h8, 4'h4,
                             4'h2, 4'h1, 4'h2};
  logic       pp_dir [7] = '{0, 0, 0, 1, 1, 0, 0};
  logic       pp_wr  [7] = '{0, 0, 0, 0, 0, 1, 0};
  logic [3:0] bl_led [4] = '{4'hF, 4'h0, 4'hF, 4'h0};
  logic       bl_wr  [4] = '{0, 1, 0, 1};

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.i_valid  = 1'b0;
    bus.i_enable = 1'b1;
    bus.i_mode   = MODE_ROT_L;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_led", bus.o_led, 4'b0001);
    check("rst_r", bus.o_ledR, 4'b0001);
    check("rst_g", bus.o_ledG, 4'b0000);
    check("rst_dir", bus.o_dir, 1'b0);
    check("rst_wrap", bus.o_wrap, 1'b0);

    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("rl_led%0d", i), bus.o_led, rl_led[i]);
      check($sformatf("rl_wr%0d", i), bus.o_wrap, rl_wr[i]);
      if (i == 3) begin
        check("rl_g", bus.o_ledG, 4'b0001);
        check("rl_r", bus.o_ledR, 4'b0000);
      end
    end
    check("rl_wrap_low", bus.o_wrap, 1'b0);

    do_reset();
    bus.i_mode = MODE_PINGPONG;
    step();
    check("pp_rld_led", bus.o_led, 4'b0001);
    check("pp_rld_wr", bus.o_wrap, 1'b0);
    for (int i = 0; i < 7; i++) begin
      step();
      check($sformatf("pp_led%0d", i), bus.o_led, pp_led[i]);
      check($sformatf("pp_dir%0d", i), bus.o_dir, pp_dir[i]);
      check($sformatf("pp_wr%0d", i), bus.o_wrap, pp_wr[i]);
    end
    check("pp_g", bus.o_ledG, 4'b0010);

    bus.i_mode = MODE_ROT_R;
    step();
    check("rr_rld_led", bus.o_led, 4'b1000);
    check("rr_rld_dir", bus.o_dir, 1'b1);
    check("rr_rld_wr", bus.o_wrap, 1'b0);
    step();
    check("rr_led", bus.o_led, 4'b0100);
    check("rr_g", bus.o_ledG, 4'b0100);

    bus.i_mode = MODE_BLINK;
    step();
    check("bl_rld_led", bus.o_led, 4'b0000);
    check("bl_rld_wr", bus.o_wrap, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("bl_led%0d", i), bus.o_led, bl_led[i]);
      check($sformatf("bl_wr%0d", i), bus.o_wrap, bl_wr[i]);
      if (i == 2) begin
        check("bl_both_r", bus.o_ledR, 4'hF);
        check("bl_both_g", bus.o_ledG, 4'hF);
      end
    end

    bus.i_enable = 1'b0;
    bus.i_mode   = MODE_ROT_L;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("en_led%0d", i), bus.o_led, 4'b0000);
      check($sformatf("en_wr%0d", i), bus.o_wrap, 1'b0);
    end
    bus.i_enable = 1'b1;
    bus.i_mode   = MODE_BLINK;
    step();
    check("en_adv_led", bus.o_led, 4'hF);
    check("en_adv_r", bus.o_ledR, 4'hF);
    check("en_adv_g", bus.o_ledG, 4'h0);
    @(negedge clk);
    check("en_hold_led", bus.o_led, 4'hF);

    do_reset();
    bus.i_mode = MODE_PINGPONG;
    step();
    step();
    step();
    check("ar_pre_led", bus.o_led, 4'b0100);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("ar_led", bus.o_led, 4'b0001);
    check("ar_r", bus.o_ledR, 4'b0001);
    check("ar_g", bus.o_ledG, 4'b0000);
    check("ar_dir", bus.o_dir, 1'b0);
    check("ar_wrap", bus.o_wrap, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
